// File: rtl/traffic_lane.sv
// traffic_lane: one lane of wrapping obstacles with frame divider, level speed-up, pause and restart
module traffic_lane #(
  parameter int N_CARS  = 4,
  parameter int DIR     = 0,
  parameter int LANE_Y  = 288,
  parameter int START_X = 0,
  parameter int SPACING = 160,
  parameter int STEP    = 1,
  parameter int DIV     = 1,
  parameter int WRAP_LO = -32,
  parameter int WRAP_HI = 672,
  parameter int XW      = 11
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   enable,
  input  logic                   restart,
  input  logic [1:0]             level,
  output logic [N_CARS*XW-1:0]   car_x,
  output logic [9:0]             lane_y,
  output logic                   lane_dir,
  output logic [N_CARS-1:0]      wrap_pulse,
  output logic                   move_tick
);
  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic signed [XW:0] LO = (XW+1)'(WRAP_LO);
  localparam logic signed [XW:0] HI = (XW+1)'(WRAP_HI);
  logic [3:0]        count;
  logic [XW:0]       s;
  logic              move;
  logic [XW-1:0]     x     [N_CARS];
  logic [XW-1:0]     x_nxt [N_CARS];
  logic [XW-1:0]     x_init[N_CARS];
  logic [N_CARS-1:0] wrap_nxt;
  assign lane_y   = 10'(LANE_Y);
  assign lane_dir = 1'(DIR);
  assign move     = enable && count == DIV_LAST;
  // level 3 saturates to the level-2 speed
  always_comb s = (XW+1)'(STEP) << (level[1] ? 2'd2 : level);
  for (genvar i = 0; i < N_CARS; i++) begin : g_car
    logic signed [XW:0] cur;
    assign x_init[i] = XW'(START_X + i*SPACING);
    assign cur = $signed({x[i][XW-1], x[i]});
    assign wrap_nxt[i] = DIR != 0 ? cur <= LO : cur >= HI;
    assign x_nxt[i] = wrap_nxt[i] ? (DIR != 0 ? HI[XW-1:0] : LO[XW-1:0])
                    : (DIR != 0 ? x[i] - s[XW-1:0] : x[i] + s[XW-1:0]);
    assign car_x[i*XW +: XW] = x[i];
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset_n || restart) begin
      for (int i = 0; i < N_CARS; i++) x[i] <= x_init[i];
      count      <= '0;
      wrap_pulse <= '0;
      move_tick  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CARS; i++) if (move) x[i] <= x_nxt[i];
      if (enable) count <= move ? 4'd0 : count + 4'd1;
      wrap_pulse <= move ? wrap_nxt : '0;
      move_tick  <= move;
    end
  end
endmodule

// File: tb/tb_traffic_lane.sv
// tb_traffic_lane: directed vectors over four lane configurations
module tb_traffic_lane;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] rst_n, en, rs;
  logic [1:0] lvl [4];
  logic [43:0] x0, x1, x3;
  logic [10:0] x2;
  logic [9:0]  y0, y1, y2, y3;
  logic        d0, d1, d2, d3, t0, t1, t2, t3;
  logic [3:0]  w0, w1, w3;
  logic        w2;
  int vectors = 0, miscompares = 0, ticks;

  traffic_lane u0 (.frame_clk(clk), .Reset_n(rst_n[0]), .enable(en[0]), .restart(rs[0]), .level(lvl[0]),
    .car_x(x0), .lane_y(y0), .lane_dir(d0), .wrap_pulse(w0), .move_tick(t0));
  traffic_lane #(.DIV(3)) u1 (.frame_clk(clk), .Reset_n(rst_n[1]), .enable(en[1]), .restart(rs[1]), .level(lvl[1]),
    .car_x(x1), .lane_y(y1), .lane_dir(d1), .wrap_pulse(w1), .move_tick(t1));
  traffic_lane #(.N_CARS(1), .DIR(1), .START_X(-20)) u2 (.frame_clk(clk), .Reset_n(rst_n[2]), .enable(en[2]),
    .restart(rs[2]), .level(lvl[2]), .car_x(x2), .lane_y(y2), .lane_dir(d2), .wrap_pulse(w2), .move_tick(t2));
  traffic_lane #(.STEP(3)) u3 (.frame_clk(clk), .Reset_n(rst_n[3]), .enable(en[3]), .restart(rs[3]), .level(lvl[3]),
    .car_x(x3), .lane_y(y3), .lane_dir(d3), .wrap_pulse(w3), .move_tick(t3));

  function automatic int car(input logic [43:0] v, input int i);
    return int'($signed(v[i*11 +: 11]));
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = '0; en = 4'b0001; rs = '0;
    for (int i = 0; i < 4; i++) lvl[i] = 2'd0;
    cyc(2);
    chk("rst_car0", car(x0, 0), 0);
    chk("rst_car1", car(x0, 1), 160);
    chk("rst_car2", car(x0, 2), 320);
    chk("rst_car3", car(x0, 3), 480);
    chk("rst_tick", int'(t0), 0);
    chk("rst_wrap", int'(w0), 0);
    chk("lane_y", int'(y0), 288);
    chk("lane_dir0", int'(d0), 0);
    rst_n[0] = 1'b1;
    cyc(1);
    chk("c1_car0", car(x0, 0), 1);
    chk("c1_car1", car(x0, 1), 161);
    chk("c1_car2", car(x0, 2), 321);
    chk("c1_car3", car(x0, 3), 481);
    for (int c = 1; c <= 193; c++) begin
      if (c > 1) cyc(1);
      chk("tick_every", int'(t0), 1);
      if (c == 192) begin
        chk("c192_car3", car(x0, 3), 672);
        chk("c192_wrap", int'(w0), 0);
      end
    end
    chk("c193_car3", car(x0, 3), -32);
    chk("c193_wrap", int'(w0), 8);
    chk("c193_car0", car(x0, 0), 193);
    chk("c193_car2", car(x0, 2), 513);
    cyc(1);
    chk("c194_wrap", int'(w0), 0);
    chk("c194_car3", car(x0, 3), -31);
    rs[0] = 1'b1;
    cyc(1);
    chk("rs_car0", car(x0, 0), 0);
    chk("rs_car3", car(x0, 3), 480);
    chk("rs_tick", int'(t0), 0);
    rs[0] = 1'b0;
    cyc(1);
    chk("rs_resume", car(x0, 0), 1);

    rst_n[1] = 1'b1; en[1] = 1'b1; ticks = 0;
    for (int c = 1; c <= 9; c++) begin
      cyc(1);
      chk("div3_tick", int'(t1), int'(c % 3 == 0));
      ticks += int'(t1);
    end
    chk("div3_ticks", ticks, 3);
    chk("div3_car0", car(x1, 0), 3);
    rst_n[1] = 1'b0;
    cyc(1);
    rst_n[1] = 1'b1;
    cyc(3);
    chk("pause_pre", car(x1, 0), 1);
    en[1] = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      cyc(1);
      chk("pause_tick", int'(t1), 0);
      chk("pause_car0", car(x1, 0), 1);
    end
    en[1] = 1'b1;
    cyc(2);
    chk("c10_tick", int'(t1), 0);
    cyc(1);
    chk("c11_tick", int'(t1), 1);
    chk("c11_car0", car(x1, 0), 2);
    cyc(3);
    chk("c14_tick", int'(t1), 1);
    chk("c14_car0", car(x1, 0), 3);
    cyc(1);
    rst_n[1] = 1'b0;
    cyc(1);
    chk("midrst_car0", car(x1, 0), 0);
    chk("midrst_tick", int'(t1), 0);
    rst_n[1] = 1'b1;
    cyc(2);
    chk("midrst_c2", int'(t1), 0);
    cyc(1);
    chk("midrst_c3", int'(t1), 1);
    chk("midrst_car", car(x1, 0), 1);

    lvl[2] = 2'd2;
    cyc(1);
    chk("dir1_rst", int'($signed(x2)), -20);
    chk("lane_dir1", int'(d2), 1);
    rst_n[2] = 1'b1; en[2] = 1'b1;
    cyc(1);
    chk("dir1_c1", int'($signed(x2)), -24);
    cyc(1);
    chk("dir1_c2", int'($signed(x2)), -28);
    cyc(1);
    chk("dir1_c3", int'($signed(x2)), -32);
    chk("dir1_c3w", int'(w2), 0);
    cyc(1);
    chk("dir1_c4", int'($signed(x2)), 672);
    chk("dir1_c4w", int'(w2), 1);
    cyc(1);
    chk("dir1_c5", int'($signed(x2)), 668);
    chk("dir1_c5w", int'(w2), 0);

    lvl[3] = 2'd3; rst_n[3] = 1'b1; en[3] = 1'b1;
    cyc(1);
    chk("lvl3", car(x3, 0), 12);
    lvl[3] = 2'd2;
    cyc(1);
    chk("lvl2", car(x3, 0), 24);
    lvl[3] = 2'd0;
    cyc(1);
    chk("lvl0", car(x3, 0), 27);
    lvl[3] = 2'd1;
    cyc(1);
    chk("lvl1", car(x3, 0), 33);
    chk("lvl1_car1", car(x3, 1), 193);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/traffic_lane.md
Name: traffic_lane

Overview:
- Parametrised lane of moving obstacles (cars/trucks/logs) for the frogger playfield. Generalises the fixed eight-car, rightward-only, one-pixel-per-frame car block.
- Drives N_CARS objects in one lane, in either direction, with a frame-rate divider, a level-dependent speed multiplier, pause, restart and per-car wrap reporting.
- Sits beside the frog controller. Its positions feed the sprite renderer and the collision checker.

Parameters:
- N_CARS, 4, number of objects in the lane (1..8)
- DIR, 0, travel direction: 0 = rightward (+x), 1 = leftward (-x)
- LANE_Y, 288, constant y coordinate of the lane (10-bit)
- START_X, 0, x position of car 0 after reset/restart (signed XW)
- SPACING, 160, x distance between consecutive cars at start (car i = START_X + i*SPACING)
- STEP, 1, base pixels moved per move event (1..15)
- DIV, 1, frames per move event (1..16)
- WRAP_LO, -32, lower wrap boundary (signed)
- WRAP_HI, 672, upper wrap boundary (signed); WRAP_LO < WRAP_HI
- XW, 11, signed x coordinate width

Ports:
- frame_clk  in  1  frame tick clock (one edge per video frame)
- Reset_n  in  1  synchronous active-low reset
- enable  in  1  1 = lane moves; 0 = paused (positions and divider hold)
- restart  in  1  synchronous reload of start positions without a full reset
- level  in  2  speed level; effective step = STEP << min(level,2)
- car_x  out  N_CARS*XW  packed signed x positions; car i occupies bits [i*XW +: XW]
- lane_y  out  10  LANE_Y, constant
- lane_dir  out  1  DIR, constant
- wrap_pulse  out  N_CARS  bit i high for exactly one cycle when car i wraps
- move_tick  out  1  high for one cycle on each move event

Behaviour:
- All state updates on posedge frame_clk only. Reset is synchronous and active-low.
- Reset (Reset_n = 0):
  - car_x[i] = START_X + i*SPACING, truncated to XW
  - divider count = 0; wrap_pulse = 0; move_tick = 0
  - lane_y / lane_dir are always the parameter values
- Priority each cycle: Reset_n low > restart > enable > hold.
- restart = 1 gives the same register result as reset. It overrides a simultaneous enable, and no move occurs that cycle.
- Divider: count runs 0..DIV-1 and advances only when enable = 1.
  - A move event occurs on the enabled cycle where count == DIV-1; count then returns to 0.
  - DIV = 1 means a move on every enabled cycle.
- enable = 0: car_x and count hold; wrap_pulse = 0; move_tick = 0. There is no catch-up on resume.
- On a move event, for each car i independently, with s = STEP << min(level,2) (level 3 is treated as 2):
  - DIR = 0: if car_x[i] >= WRAP_HI then car_x[i] <= WRAP_LO and wrap_pulse[i] <= 1; else car_x[i] <= car_x[i] + s.
  - DIR = 1: if car_x[i] <= WRAP_LO then car_x[i] <= WRAP_HI and wrap_pulse[i] <= 1; else car_x[i] <= car_x[i] - s.
- Overshoot:
  - The comparison uses the pre-update value, so a car may sit past the boundary by up to s-1 pixels for one move period.
  - The wrap loads the boundary exactly; the remainder is discarded.
- All arithmetic is signed XW-bit. Compare in XW+1 bits so that WRAP_HI + s cannot overflow.
- wrap_pulse and move_tick are registered and de-assert on the next cycle that is not a wrapping/move event.
- A level change takes effect at the next move event. It has no effect on the divider.
- Several cars may wrap on the same move event; each raises its own bit.
- Reset asserted mid-divide discards the partial count.

Test Plan:
- Defaults, Reset_n = 0 for 2 cycles, then 1, enable = 1 → after reset car_x = {0,160,320,480}; after 1 cycle {1,161,321,481}; move_tick = 1 each cycle.
- Defaults, enable = 1 for 193 cycles → car 3 reaches 672 at cycle 192 and -32 at cycle 193 with wrap_pulse = 4'b1000 for that cycle only; car 0 = 193.
- DIV = 3, enable = 1 for 9 cycles → exactly 3 move_tick pulses, on cycles 3, 6, 9; car 0 = 3. Drop enable at cycle 4 for 5 cycles → car_x frozen at 1, no pulses, then resumes with moves at cycles 11 and 14.
- DIR = 1, START_X = -20, N_CARS = 1, level = 2 (s = 4) → -24, -28, -32, then 672 with wrap_pulse[0] = 1, then 668.
- level = 3, STEP = 3 → step of 12 per move, identical to level = 2; level 0 gives 3.
- Mid-run restart = 1 together with enable = 1 → next cycle car_x = start positions, move_tick = 0. Mid-run Reset_n = 0 on a non-edge-aligned divider count → positions reset, and the first move occurs DIV enabled cycles after release.
